// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared types and constants for the counter_seq sequencer.
//                Provides the sequencer state encoding and the default
//                counter width used by counter_seq and counter_core.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    // Default width of the counter, the command fields and the
    // remaining-steps register.
    localparam int WIDTH_DEFAULT = 8;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : counter_seq_pkg
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
//  Module      : counter_core
//  Description : WIDTH-bit wrapping up-counter with synchronous load and
//                count enable. Load has priority over enable.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-low reset (count -> 0)
//                load     - load load_val into the counter
//                load_val - value to load
//                en       - increment by one (mod 2^WIDTH)
//                count    - current counter value
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            // Unsigned add; the carry out is dropped so the value wraps.
            count <= count + C_ONE;
        end
    end

endmodule : counter_core
`default_nettype wire

// File: rtl/counter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq
//  Description : Command-driven sequencer for a wrapping up-counter. A
//                (start, length) command is accepted over a valid/ready
//                handshake in IDLE; the counter is loaded with start and
//                then stepped exactly length times, after which done pulses
//                for one cycle. A running sequence can be cut short with
//                abort, which is reported through aborted alongside done.
//
//  Build option: COUNTER_SEQ_RELOAD_EN
//                When defined, adds input cmd_repeat. A command accepted
//                with cmd_repeat=1 reloads its start/length in DONE and
//                runs again indefinitely until aborted.
//
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-low reset
//                cmd_valid  - command present
//                cmd_ready  - command can be accepted (IDLE only)
//                cmd_start  - counter load value
//                cmd_len    - number of increments (0 legal)
//                cmd_repeat - (COUNTER_SEQ_RELOAD_EN only) repeat command
//                abort      - terminate a running sequence
//                count      - counter value
//                busy       - state is not IDLE
//                done       - one-cycle end-of-sequence pulse
//                aborted    - valid with done; sequence ended by abort
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_len,
`ifdef COUNTER_SEQ_RELOAD_EN
    input  logic             cmd_repeat,
`endif
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_next;
    logic             aborted_next;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;

`ifdef COUNTER_SEQ_RELOAD_EN
    // Copy of the accepted command, replayed on every repeat.
    logic             rpt;
    logic             rpt_next;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] start_q_next;
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_q_next;
`endif

    // ------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------
    counter_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count)
    );

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            rem     <= '0;
            aborted <= 1'b0;
`ifdef COUNTER_SEQ_RELOAD_EN
            rpt     <= 1'b0;
            start_q <= '0;
            len_q   <= '0;
`endif
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            aborted <= aborted_next;
`ifdef COUNTER_SEQ_RELOAD_EN
            rpt     <= rpt_next;
            start_q <= start_q_next;
            len_q   <= len_q_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        rem_next     = rem;
        aborted_next = aborted;
        load         = 1'b0;
        load_val     = cmd_start;
        en           = 1'b0;
`ifdef COUNTER_SEQ_RELOAD_EN
        rpt_next     = rpt;
        start_q_next = start_q;
        len_q_next   = len_q;
`endif

        case (state)
            ST_IDLE: begin
                // cmd_ready is high throughout IDLE, so valid alone accepts.
                if (cmd_valid) begin
                    load         = 1'b1;
                    load_val     = cmd_start;
                    rem_next     = cmd_len;
                    aborted_next = 1'b0;
                    state_next   = (cmd_len != '0) ? ST_RUN : ST_DONE;
`ifdef COUNTER_SEQ_RELOAD_EN
                    rpt_next     = cmd_repeat;
                    start_q_next = cmd_start;
                    len_q_next   = cmd_len;
`endif
                end
            end

            ST_RUN: begin
                // Abort wins over the final increment: the count is frozen.
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = ST_DONE;
`ifdef COUNTER_SEQ_RELOAD_EN
                    rpt_next     = 1'b0;
`endif
                end else begin
                    en       = 1'b1;
                    rem_next = rem - C_ONE;
                    if (rem == C_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
`ifdef COUNTER_SEQ_RELOAD_EN
                // Repeat: done still pulses this cycle while the command is
                // replayed on the same edge.
                if (rpt && !aborted) begin
                    load       = 1'b1;
                    load_val   = start_q;
                    rem_next   = len_q;
                    state_next = (len_q != '0) ? ST_RUN : ST_DONE;
                end
`endif
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs, decoded from state only
    // ------------------------------------------------------------------
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule : counter_seq
`default_nettype wire

// File: doc/counter_seq.md
# counter_seq

Command-driven sequencer for an 8-bit wrapping up-counter datapath. Accepts a (start, length) command over a valid/ready handshake, loads the counter, steps it exactly `length` times, then pulses `done`. Sits between a host/testbench command source and the counter core, so counting windows are scheduled rather than free-running from reset.

## Interface
- `WIDTH`, 8, width of the counter, `cmd_start`, `cmd_len` and the remaining-steps register.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command; high only in IDLE.
- `cmd_start`  in  WIDTH  value loaded into the counter on accept.
- `cmd_len`  in  WIDTH  number of increments to perform; 0 is legal.
- `abort`  in  1  terminate a running sequence.
- `count`  out  WIDTH  counter value.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at end of sequence.
- `aborted`  out  1  valid with `done`; 1 if the sequence ended by `abort`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready` at an edge: `count`←`cmd_start`, `rem`←`cmd_len`, `aborted`←0. Next state is RUN if `cmd_len`≠0, otherwise DONE.
- RUN: each edge `count`←`count`+1 mod 2^WIDTH and `rem`←`rem`−1. When `rem`==1, go to DONE.
- RUN with `abort`=1: `count` holds, `aborted`←1, go to DONE. Abort has priority over the final increment.
- DONE: `done`=1 for exactly this cycle, then go to IDLE. `count` holds its final value until the next accept.
- `abort` is ignored in IDLE and DONE. `cmd_valid` outside IDLE is ignored and not queued; the source must hold it.
- Arithmetic is unsigned. `count` wraps 2^WIDTH−1→0 silently, e.g. start 250, len 10 → final count 4.
- `count`, `cmd_ready`, `busy` and `done` are driven from registers or decoded from state only. There are no combinational paths from inputs to outputs.

## Timing
- Reset (`rst`=0, async): state IDLE, `count`=0, `rem`=0, `aborted`=0, `done`=0, `busy`=0. `cmd_ready`=1, but no accept occurs while `rst` is low.
- Reset mid-sequence aborts immediately without a `done` pulse.
- Accept at edge k:
  - `count`=`cmd_start` after edge k.
  - `count`=`cmd_start`+`len` after edge k+len.
  - `done` is high between edges k+len and k+len+1.
  - `cmd_ready` is high again after edge k+len+1.
- `len`=0: `done` is high in the cycle after accept.
- Command-to-command spacing is at least `len`+2 cycles.

## Configuration
- `COUNTER_SEQ_RELOAD_EN` defined:
  - Adds input `cmd_repeat` (1 bit), latched on accept.
  - In DONE with repeat set and `aborted`=0: `done` still pulses, and on the same edge `count`←start and `rem`←len are reloaded and the sequencer re-enters RUN (DONE if len=0) instead of IDLE. Repeats indefinitely.
  - `abort` clears repeat and ends normally via DONE→IDLE.
- `COUNTER_SEQ_RELOAD_EN` undefined: the port is absent and every command is one-shot.

## Structure
- Package `counter_seq_pkg`: state enum (IDLE, RUN, DONE) and default `WIDTH` constant.
- Sub-module `counter_core`: WIDTH-bit counter with `load`, `load_val` and `en`, plus async active-low reset to 0. `counter_seq` holds the FSM and the `rem` register and drives `counter_core`.

## Test plan
- Reset then accept start=5, len=3 → `count` 5,6,7,8 on successive edges; `done`=1 one cycle with `aborted`=0; `cmd_ready` high one cycle later.
- start=250, len=10 → wraps; final `count`=4 at `done`.
- len=0, start=0x42 → `count`=0x42, `done` next cycle, no increment.
- start=0, len=20, `abort` after 4 increments → `count` holds 4; `done`=1 with `aborted`=1; next command accepted normally.
- `cmd_valid` held continuously with back-to-back commands; `rst` pulsed low mid-RUN → count 0, IDLE, no `done`.
- RELOAD_EN defined: start=0, len=2, repeat=1 → `count` 0,1,2,0,1,2,…; `done` every 3rd cycle until `abort`.
